// File: rtl/mix_columns_pkg.sv
// Shared constants and GF(2^8) helpers for the AES MixColumns stage.
package mix_columns_pkg;

  localparam int unsigned AES_BLOCK_WIDTH = 128;
  localparam int unsigned AES_CPU_WIDTH   = 32;
  localparam int unsigned AES_PNTR_WIDTH  = 2;

  localparam logic [7:0] AES_POLY_REDUCE = 8'h1B;

  localparam int unsigned DBG_W          = 3;
  localparam int unsigned DBG_RD_XFER    = 0;
  localparam int unsigned DBG_IN_STALL   = 1;
  localparam int unsigned DBG_CNTR_WRAP  = 2;

  typedef enum logic {
    RD_SEL_PNTR_CNTR = 1'b0,
    RD_SEL_DEBUG     = 1'b1
  } rd_sel_e;

  typedef logic [31:0] word_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_REDUCE : 8'h00);
  endfunction

endpackage

// File: rtl/mix_columns_if.sv
// Upstream/downstream valid-ready bus of the MixColumns stage.
interface mix_columns_if
  import mix_columns_pkg::*;
#(
  parameter int unsigned BLOCK_DATA_WIDTH = AES_BLOCK_WIDTH,
  parameter int unsigned PNTR_W           = AES_PNTR_WIDTH
);
  logic [BLOCK_DATA_WIDTH-1:0] data_in;
  logic                        data_in_vld;
  logic                        data_in_last;
  logic                        data_in_rdy;
  logic [PNTR_W-1:0]           pntr_num_in;
  logic [BLOCK_DATA_WIDTH-1:0] data_out;
  logic                        data_out_vld;
  logic                        data_out_rdy;
  logic [PNTR_W-1:0]           pntr_num_out;

  modport master (
    output data_in, data_in_vld, data_in_last, pntr_num_in, data_out_rdy,
    input  data_in_rdy, data_out, data_out_vld, pntr_num_out
  );

  modport slave (
    input  data_in, data_in_vld, data_in_last, pntr_num_in, data_out_rdy,
    output data_in_rdy, data_out, data_out_vld, pntr_num_out
  );
endinterface

// File: rtl/mix_columns_single_column.sv
// One MixColumns column: {02 03 01 01} circulant over GF(2^8), xtime supplied precomputed.
module mix_single_column
  import mix_columns_pkg::*;
(
  input  word_t col_in,
  input  word_t col_xt,
  input  logic  bypass,
  output word_t col_out
);
  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;
  logic [7:0] r0, r1, r2, r3;

  always_comb begin
    {a0, a1, a2, a3} = col_in;
    {x0, x1, x2, x3} = col_xt;
    // 3a is formed as xtime(a) ^ a
    r0 = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
    r1 = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
    r2 = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
    r3 = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
    col_out = bypass ? col_in : {r0, r1, r2, r3};
  end
endmodule

// File: rtl/mix_columns.sv
// AES-128 MixColumns round stage: two-stage valid/ready pipeline with per-tag counters and debug bits.
module mix_columns
  import mix_columns_pkg::*;
#(
  parameter int unsigned BLOCK_DATA_WIDTH = AES_BLOCK_WIDTH,
  parameter int unsigned CPU_DATA_WIDTH   = AES_CPU_WIDTH,
  parameter int unsigned PNTR_W           = AES_PNTR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  mix_columns_if.slave              bus,
  input  logic                      cpu_rd,
  input  logic                      cpu_rd_sel,
  output logic [CPU_DATA_WIDTH-1:0] cpu_rd_data
);
  localparam int unsigned NCOL   = BLOCK_DATA_WIDTH / 32;
  localparam int unsigned NBYTE  = BLOCK_DATA_WIDTH / 8;
  localparam int unsigned NTAG   = 2 ** PNTR_W;
  localparam int unsigned CNTR_W = NTAG * 8;

  logic                        s1_vld_q, s1_vld_d;
  logic [BLOCK_DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [BLOCK_DATA_WIDTH-1:0] s1_xt_q, s1_xt_d;
  logic                        s1_last_q, s1_last_d;
  logic [PNTR_W-1:0]           s1_pntr_q, s1_pntr_d;
  logic                        s2_vld_q, s2_vld_d;
  logic [BLOCK_DATA_WIDTH-1:0] s2_data_q, s2_data_d;
  logic [PNTR_W-1:0]           s2_pntr_q, s2_pntr_d;
  logic [CNTR_W-1:0]           cntr_q, cntr_d;
  logic [DBG_W-1:0]            dbg_q, dbg_d;
  logic [CPU_DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

  logic                        s1_load, s2_load, in_xfer, rd_clr;
  logic [DBG_W-1:0]            dbg_set;
  logic [BLOCK_DATA_WIDTH-1:0] mixed;

  for (genvar c = 0; c < NCOL; c++) begin : g_col
    mix_single_column u_mix (
      .col_in (s1_data_q[BLOCK_DATA_WIDTH-1-32*c -: 32]),
      .col_xt (s1_xt_q[BLOCK_DATA_WIDTH-1-32*c -: 32]),
      .bypass (s1_last_q),
      .col_out(mixed[BLOCK_DATA_WIDTH-1-32*c -: 32])
    );
  end

  always_comb begin
    s2_load   = ~s2_vld_q | bus.data_out_rdy;
    s1_load   = ~s1_vld_q | s2_load;
    in_xfer   = bus.data_in_vld & s1_load;

    s1_vld_d  = s1_vld_q;
    s1_data_d = s1_data_q;
    s1_xt_d   = s1_xt_q;
    s1_last_d = s1_last_q;
    s1_pntr_d = s1_pntr_q;
    s2_vld_d  = s2_vld_q;
    s2_data_d = s2_data_q;
    s2_pntr_d = s2_pntr_q;
    cntr_d    = cntr_q;
    dbg_set   = '0;
    rd_data_d = rd_data_q;

    if (s1_load) s1_vld_d = bus.data_in_vld;
    if (in_xfer) begin
      s1_data_d = bus.data_in;
      s1_last_d = bus.data_in_last;
      s1_pntr_d = bus.pntr_num_in;
      for (int unsigned i = 0; i < NBYTE; i++)
        s1_xt_d[i*8 +: 8] = xtime(bus.data_in[i*8 +: 8]);
    end

    // Data/tag only move with a valid block so a drained output keeps its last value.
    if (s2_load) s2_vld_d = s1_vld_q;
    if (s2_load && s1_vld_q) begin
      s2_data_d = mixed;
      s2_pntr_d = s1_pntr_q;
    end

    for (int unsigned t = 0; t < NTAG; t++) begin
      if (in_xfer && bus.pntr_num_in == PNTR_W'(t)) begin
        if (cntr_q[t*8 +: 8] == 8'hFF) dbg_set[DBG_CNTR_WRAP] = 1'b1;
        cntr_d[t*8 +: 8] = cntr_q[t*8 +: 8] + 8'd1;
      end
    end

    dbg_set[DBG_RD_XFER]  = cpu_rd & in_xfer;
    dbg_set[DBG_IN_STALL] = bus.data_in_vld & ~s1_load;
    rd_clr = cpu_rd & (rd_sel_e'(cpu_rd_sel) == RD_SEL_DEBUG);
    // A set arriving with the read-clear survives it.
    dbg_d  = (rd_clr ? '0 : dbg_q) | dbg_set;

    if (cpu_rd) begin
      if (rd_sel_e'(cpu_rd_sel) == RD_SEL_DEBUG) begin
        rd_data_d = '0;
        rd_data_d[DBG_W-1:0] = dbg_q;
      end else begin
        rd_data_d = CPU_DATA_WIDTH'(cntr_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
      s1_xt_q   <= '0;
      s1_last_q <= 1'b0;
      s1_pntr_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_pntr_q <= '0;
      cntr_q    <= '0;
      dbg_q     <= '0;
      rd_data_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_data_q <= s1_data_d;
      s1_xt_q   <= s1_xt_d;
      s1_last_q <= s1_last_d;
      s1_pntr_q <= s1_pntr_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
      s2_pntr_q <= s2_pntr_d;
      cntr_q    <= cntr_d;
      dbg_q     <= dbg_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.data_in_rdy  = s1_load;
  assign bus.data_out     = s2_data_q;
  assign bus.data_out_vld = s2_vld_q;
  assign bus.pntr_num_out = s2_pntr_q;
  assign cpu_rd_data      = rd_data_q;

endmodule
